// File: rtl/led_bus_pkg.sv
// Shared definitions for the LED peripheral write-port arbiter.
package led_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned GAP_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first asserted request after last_grant_i.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);

    int idx;

    // Scan from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx = (int'(last_grant_i) + k) % int'(NUM_REQ);
            if (req_i[IDX_W'(idx)]) begin
                winner_o = IDX_W'(idx);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_write_arbiter.sv
// Round-robin arbiter sharing the LED peripheral write port; one registered
// single-cycle write per grant followed by a fixed idle gap.
module led_write_arbiter
    import led_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         data_address,
    output logic [DATA_W-1:0]         write_data,
    output logic                      busy,
    output logic [IDX_W-1:0]          last_grant
);

    state_e                 state_q, state_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   busy_q, busy_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;

    logic [IDX_W-1:0]       winner;
    logic                   winner_valid;
    logic [ADDR_W-1:0]      addr_arr [NUM_REQ];
    logic [DATA_W-1:0]      data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .valid_o      (winner_valid)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        gnt_d        = '0;
        wr_en_d      = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (winner_valid) begin
                    state_d      = ST_WRITE;
                    wr_en_d      = 1'b1;
                    gnt_d        = NUM_REQ'(1) << winner;
                    addr_d       = addr_arr[winner];
                    data_d       = data_arr[winner];
                    last_grant_d = winner;
                end
            end
            ST_WRITE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_CNT_W'(GAP_CYCLES - 1);
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            gnt_q        <= '0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            gnt_q        <= gnt_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt          = gnt_q;
    assign wr_en        = wr_en_q;
    assign data_address = addr_q;
    assign write_data   = data_q;
    assign busy         = busy_q;
    assign last_grant   = last_grant_q;

endmodule

// File: tb/tb_led_write_arbiter.sv
// Bench for led_write_arbiter: transaction-level model feeding a scoreboard.
module tb_led_write_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 8;
    localparam int unsigned GAP = 2;
    localparam int unsigned IW  = $clog2(N);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    gnt;
    logic            wr_en;
    logic [AW-1:0]   data_address;
    logic [DW-1:0]   write_data;
    logic            busy;
    logic [IW-1:0]   last_grant;

    logic            rst_z = 1'b1;
    logic [N-1:0]    req_z = '0;
    logic [N*AW-1:0] req_addr_z = '0;
    logic [N*DW-1:0] req_data_z = '0;
    logic [N-1:0]    gnt_z;
    logic            wr_en_z;
    logic [AW-1:0]   data_address_z;
    logic [DW-1:0]   write_data_z;
    logic            busy_z;
    logic [IW-1:0]   last_grant_z;

    always #5 clk = ~clk;

    led_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .wr_en(wr_en), .data_address(data_address), .write_data(write_data),
        .busy(busy), .last_grant(last_grant)
    );

    led_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(0)) u_dut_nogap (
        .clk(clk), .rst(rst_z), .req(req_z), .req_addr(req_addr_z), .req_data(req_data_z),
        .gnt(gnt_z), .wr_en(wr_en_z), .data_address(data_address_z), .write_data(write_data_z),
        .busy(busy_z), .last_grant(last_grant_z)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int            edge_n;
        logic [N-1:0]  g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    int            edge_cnt    = 0;
    int            m_last      = N - 1;
    int            m_free      = 0;
    int            m_busy_last = -1;
    logic [AW-1:0] m_addr      = '0;
    logic [DW-1:0] m_data      = '0;

    // Reference model: a write may be sampled every 2+GAP edges once idle.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (rst) begin
                m_last      = N - 1;
                m_free      = edge_cnt + 1;
                m_busy_last = edge_cnt - 1;
                m_addr      = '0;
                m_data      = '0;
                sb.delete();
            end else if (edge_cnt >= m_free && req != '0) begin
                int w;
                exp_t x;
                w = -1;
                for (int k = 1; k <= int'(N); k++) begin
                    int idx;
                    idx = (m_last + k) % int'(N);
                    if (w < 0 && req[idx]) w = idx;
                end
                x.edge_n = edge_cnt;
                x.g      = N'(1) << w;
                x.a      = req_addr[w*AW +: AW];
                x.d      = req_data[w*DW +: DW];
                sb.push_back(x);
                m_last      = w;
                m_free      = edge_cnt + 2 + int'(GAP);
                m_busy_last = edge_cnt + int'(GAP);
                m_addr      = x.a;
                m_data      = x.d;
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT presents a write.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].edge_n < edge_cnt) begin
                chk("missed_write_edge", 32'(edge_cnt), 32'(sb[0].edge_n));
                void'(sb.pop_front());
            end
            if (wr_en || gnt != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {31'd0, wr_en}, 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("write_edge", 32'(edge_cnt), 32'(x.edge_n));
                    chk("wr_en", {31'd0, wr_en}, 32'd1);
                    chk("gnt", 32'(gnt), 32'(x.g));
                end
            end
            chk("busy", {31'd0, busy}, {31'd0, (edge_cnt <= m_busy_last)});
            chk("last_grant", 32'(last_grant), 32'(m_last));
            chk("data_address", 32'(data_address), 32'(m_addr));
            chk("write_data", 32'(write_data), 32'(m_data));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit found;

        // Reset for two edges, then check reset values explicitly.
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_addr", 32'(data_address), 32'd0);
        chk("rst_data", 32'(write_data), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'd3);

        // Single-cycle request from requester 1.
        cyc(1);
        req_addr[1*AW +: AW] = 8'h01;
        req_data[1*DW +: DW] = 8'hA5;
        req = 4'b0010;
        cyc(1);
        req = 4'b0000;
        cyc(5);

        // All requesters held continuously.
        for (int i = 0; i < int'(N); i++) begin
            req_addr[i*AW +: AW] = AW'($urandom);
            req_data[i*DW +: DW] = DW'($urandom);
        end
        req = 4'b1111;
        cyc(22);
        req = 4'b0000;
        cyc(5);

        // Request raised during GAP and withdrawn before IDLE samples it.
        req_addr[0 +: AW] = 8'h3C;
        req_data[0 +: DW] = 8'hC3;
        req = 4'b0001;
        cyc(1);
        req = 4'b0000;
        cyc(1);
        req_addr[2*AW +: AW] = 8'hEE;
        req_data[2*DW +: DW] = 8'h77;
        req = 4'b0100;
        cyc(2);
        req = 4'b0000;
        cyc(5);

        // Reset during GAP after granting requester 3.
        req_addr[3*AW +: AW] = 8'h99;
        req_data[3*DW +: DW] = 8'h66;
        req = 4'b1000;
        cyc(1);
        req = 4'b0000;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        req = 4'b1001;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_en) begin
                chk("first_gnt_after_rst", 32'(gnt), 32'd1);
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("first_gnt_after_rst_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req = 4'b1000;
        cyc(6);
        req = 4'b0000;
        cyc(5);

        // Randomized requesters that obey the hold/drop rules, with rare resets.
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < int'(N); i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_addr[i*AW +: AW] = AW'($urandom);
                        req_data[i*DW +: DW] = DW'($urandom);
                        req[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            cyc(1);
        end
        rst = 1'b0;
        req = '0;
        cyc(8);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        // Zero-gap build: a held request writes every other cycle.
        rst_z = 1'b0;
        req_addr_z[0 +: AW] = 8'h42;
        req_data_z[0 +: DW] = 8'h24;
        req_z = 4'b0001;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wr_en_z) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("nogap_first_write_timeout", 32'd0, 32'd1);
        for (int j = 0; j < 10; j++) begin
            chk("nogap_wr_en", {31'd0, wr_en_z}, {31'd0, (j % 2 == 0)});
            chk("nogap_busy", {31'd0, busy_z}, {31'd0, (j % 2 == 0)});
            chk("nogap_gnt", 32'(gnt_z), (j % 2 == 0) ? 32'd1 : 32'd0);
            chk("nogap_addr", 32'(data_address_z), 32'h42);
            @(negedge clk);
        end
        req_z = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
